// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: one outstanding load/store at a time, with
// configurable wait states, byte/half/word lanes, load extension and error flags.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    // Handshake: a request is taken on an edge where req_valid & req_ready are both
    // high; a response is retired on an edge where rsp_valid & rsp_ready are both high.
    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT    = 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        l_we;
    logic [31:0] l_addr;
    logic [1:0]  l_size;
    logic        l_uns;
    logic [31:0] l_wdata;

    logic [31:0] mem [DEPTH_WORDS];

    logic        a_we;
    logic [31:0] a_addr;
    logic [1:0]  a_size;
    logic        a_uns;
    logic [31:0] a_wdata;
    logic        a_err;
    logic        do_access;
    logic [AW-1:0] widx;
    logic [31:0] rword;
    logic [31:0] rword_sh;
    logic [15:0] rhalf;
    logic [31:0] load_data;
    logic [31:0] res_rdata;
    logic [3:0]  wmask;
    logic [31:0] wlanes;

    assign req_ready = (state == S_IDLE) && !rst;

    // With zero latency the access happens on the accept edge, so the live request
    // is used instead of the (not yet loaded) latched copy.
    always_comb begin
        if (state == S_IDLE) begin
            a_we    = req_we;
            a_addr  = req_addr;
            a_size  = req_size;
            a_uns   = req_unsigned;
            a_wdata = req_wdata;
        end else begin
            a_we    = l_we;
            a_addr  = l_addr;
            a_size  = l_size;
            a_uns   = l_uns;
            a_wdata = l_wdata;
        end
    end

    assign do_access = ((state == S_IDLE) && req_valid && (LATENCY == 0)) ||
                       ((state == S_WAIT) && (cnt == 4'd0));

    assign a_err = (a_size == 2'b11) ||
                   ((a_size == 2'b01) && a_addr[0]) ||
                   ((a_size == 2'b10) && (a_addr[1:0] != 2'b00)) ||
                   ({1'b0, a_addr} >= LIMIT);

    assign widx     = a_addr[AW+1:2];
    assign rword    = mem[widx];
    assign rword_sh = rword >> {a_addr[1:0], 3'b000};
    assign rhalf    = a_addr[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        load_data = 32'h0;
        case (a_size)
            2'b00:   load_data = a_uns ? {24'h0, rword_sh[7:0]} : {{24{rword_sh[7]}}, rword_sh[7:0]};
            2'b01:   load_data = a_uns ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
            2'b10:   load_data = rword;
            default: load_data = 32'h0;
        endcase
    end

    assign res_rdata = (a_err || a_we) ? 32'h0 : load_data;

    always_comb begin
        wmask  = 4'b0000;
        wlanes = a_wdata;
        case (a_size)
            2'b00: begin
                wmask  = 4'b0001 << a_addr[1:0];
                wlanes = {4{a_wdata[7:0]}};
            end
            2'b01: begin
                wmask  = a_addr[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{a_wdata[15:0]}};
            end
            2'b10:   wmask = 4'b1111;
            default: wmask = 4'b0000;
        endcase
    end

    // Memory is deliberately not reset; a reset on the access edge cancels the write.
    always_ff @(posedge clk) begin
        if (!rst && do_access && a_we && !a_err) begin
            for (int k = 0; k < 4; k++) begin
                if (wmask[k]) mem[widx][8*k +: 8] <= wlanes[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            l_we      <= 1'b0;
            l_addr    <= 32'h0;
            l_size    <= 2'b00;
            l_uns     <= 1'b0;
            l_wdata   <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        l_we    <= req_we;
                        l_addr  <= req_addr;
                        l_size  <= req_size;
                        l_uns   <= req_unsigned;
                        l_wdata <= req_wdata;
                        if (LATENCY == 0) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= res_rdata;
                            rsp_err   <= a_err;
                        end else begin
                            cnt   <= CNT_INIT;
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= res_rdata;
                        rsp_err   <= a_err;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'h0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: three instances (LATENCY 2, 4, 0) share
// clock and reset; a byte-array reference model supplies every expected response.
module tb_data_mem_responder;
    localparam int DW  = 64;
    localparam int LIM = 4 * DW;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        req_valid    [3];
    logic        req_ready    [3];
    logic        req_we       [3];
    logic [31:0] req_addr     [3];
    logic [1:0]  req_size     [3];
    logic        req_unsigned [3];
    logic [31:0] req_wdata    [3];
    logic        rsp_valid    [3];
    logic        rsp_ready    [3];
    logic [31:0] rsp_rdata    [3];
    logic        rsp_err      [3];

    logic [7:0]  mbytes [3][LIM];
    logic [32:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;
    time         last_acc;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(DW), .LATENCY(2)) u_lat2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

    data_mem_responder #(.DEPTH_WORDS(DW), .LATENCY(4)) u_lat4 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

    data_mem_responder #(.DEPTH_WORDS(DW), .LATENCY(0)) u_lat0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
        .req_addr(req_addr[2]), .req_size(req_size[2]), .req_unsigned(req_unsigned[2]),
        .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 4 : 0);
    endfunction

    task automatic check(input string tag, input logic [32:0] got, input logic [32:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Reference model: little-endian byte array; returns {err, rdata}.
    function automatic logic [32:0] model_txn(input int d, input bit we, input logic [31:0] a,
                                              input logic [1:0] sz, input bit uns,
                                              input logic [31:0] wd);
        bit          err;
        int          ai;
        logic [31:0] v;
        err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) ||
              (a >= 32'(LIM));
        if (err) return {1'b1, 32'h0};
        ai = int'(a);
        if (we) begin
            mbytes[d][ai] = wd[7:0];
            if (sz != 2'b00) mbytes[d][ai+1] = wd[15:8];
            if (sz == 2'b10) begin
                mbytes[d][ai+2] = wd[23:16];
                mbytes[d][ai+3] = wd[31:24];
            end
            return 33'h0;
        end
        if (sz == 2'b00)
            v = uns ? {24'h0, mbytes[d][ai]} : {{24{mbytes[d][ai][7]}}, mbytes[d][ai]};
        else if (sz == 2'b01)
            v = uns ? {16'h0, mbytes[d][ai+1], mbytes[d][ai]}
                    : {{16{mbytes[d][ai+1][7]}}, mbytes[d][ai+1], mbytes[d][ai]};
        else
            v = {mbytes[d][ai+3], mbytes[d][ai+2], mbytes[d][ai+1], mbytes[d][ai]};
        return {1'b0, v};
    endfunction

    task automatic drive_idle(input int d);
        req_valid[d]    = 1'b0;
        req_we[d]       = 1'b0;
        req_addr[d]     = 32'h0;
        req_size[d]     = 2'b00;
        req_unsigned[d] = 1'b0;
        req_wdata[d]    = 32'h0;
        rsp_ready[d]    = 1'b0;
    endtask

    task automatic txn(input int d, input bit we, input logic [31:0] a, input logic [1:0] sz,
                       input bit uns, input logic [31:0] wd, input int hold, input string tag);
        int          n;
        logic [32:0] got;
        logic [32:0] want;
        exp_q.push_back(model_txn(d, we, a, sz, uns, wd));
        @(negedge clk);
        n = 0;
        while (!req_ready[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rdy"}, 33'(req_ready[d]), 33'd1);
        req_valid[d]    = 1'b1;
        req_we[d]       = we;
        req_addr[d]     = a;
        req_size[d]     = sz;
        req_unsigned[d] = uns;
        req_wdata[d]    = wd;
        rsp_ready[d]    = (hold == 0);
        @(posedge clk);
        last_acc = $time;
        #1;
        // Scramble the request after accept: it must have no effect.
        req_valid[d]    = 1'b0;
        req_we[d]       = 1'($urandom_range(0, 1));
        req_addr[d]     = $urandom;
        req_size[d]     = 2'($urandom_range(0, 3));
        req_unsigned[d] = 1'($urandom_range(0, 1));
        req_wdata[d]    = $urandom;
        n = 0;
        while (!rsp_valid[d] && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_lat"}, 33'(n), 33'(lat_of(d)));
        got  = {rsp_err[d], rsp_rdata[d]};
        want = exp_q.pop_front();
        check(tag, got, want);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_bp_valid"}, 33'(rsp_valid[d]), 33'd1);
            check({tag, "_bp_data"}, {rsp_err[d], rsp_rdata[d]}, got);
            check({tag, "_bp_rdy"}, 33'(req_ready[d]), 33'd0);
        end
        if (hold > 0) begin
            @(negedge clk);
            rsp_ready[d] = 1'b1;
        end
        @(posedge clk);
        #1;
        rsp_ready[d] = 1'b0;
        check({tag, "_post_rdy"}, 33'(req_ready[d]), 33'd1);
        check({tag, "_post_valid"}, 33'(rsp_valid[d]), 33'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        time t_prev;
        for (int d = 0; d < 3; d++) drive_idle(d);
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check("rst_rdy", 33'(req_ready[d]), 33'd0);
            check("rst_out", {rsp_valid[d], rsp_err[d], rsp_rdata[d]} , 33'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) check("rel_rdy", 33'(req_ready[d]), 33'd1);

        // Word store/load, LATENCY=2
        txn(0, 1, 32'h10, 2'b10, 0, 32'hDEADBEEF, 0, "st_w");
        txn(0, 0, 32'h10, 2'b10, 0, 32'h0, 0, "ld_w");
        // Sub-word store and extension
        txn(0, 1, 32'h20, 2'b10, 0, 32'h11223344, 0, "pre_20");
        txn(0, 1, 32'h21, 2'b00, 0, 32'hABCDEF80, 0, "st_b21");
        txn(0, 0, 32'h20, 2'b10, 0, 32'h0, 0, "ld_w20");
        txn(0, 0, 32'h21, 2'b00, 0, 32'h0, 0, "ld_bs21");
        txn(0, 0, 32'h21, 2'b00, 1, 32'h0, 0, "ld_bu21");
        txn(0, 0, 32'h22, 2'b01, 0, 32'h0, 0, "ld_hs22");
        txn(0, 1, 32'h12, 2'b01, 0, 32'h0000F00D, 0, "st_h12");
        txn(0, 0, 32'h12, 2'b01, 1, 32'h0, 0, "ld_hu12");
        txn(0, 0, 32'h12, 2'b01, 0, 32'h0, 0, "ld_hs12");
        txn(0, 0, 32'h10, 2'b10, 1, 32'h0, 0, "ld_w10");
        // Errors
        txn(0, 1, 32'h23, 2'b01, 0, 32'h0000FFFF, 0, "err_h23");
        txn(0, 0, 32'h20, 2'b10, 0, 32'h0, 0, "rb_w20");
        txn(0, 0, 32'(LIM), 2'b10, 0, 32'h0, 0, "err_oor");
        txn(0, 0, 32'(LIM - 1), 2'b00, 1, 32'h0, 0, "err_last_b");
        txn(0, 0, 32'h20, 2'b11, 0, 32'h0, 0, "err_sz3");
        txn(0, 1, 32'h11, 2'b10, 0, 32'h12345678, 0, "err_w11");
        // Back-pressure
        txn(0, 0, 32'h20, 2'b10, 0, 32'h0, 5, "bp");

        // Reset mid-WAIT, LATENCY=4
        txn(1, 1, 32'h40, 2'b10, 0, 32'h0, 0, "pre_40");
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_addr[1]  = 32'h40;
        req_size[1]  = 2'b10;
        req_wdata[1] = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_rdy", 33'(req_ready[1]), 33'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_rel_rdy", 33'(req_ready[1]), 33'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("midrst_novalid", 33'(rsp_valid[1]), 33'd0);
        end
        txn(1, 0, 32'h40, 2'b10, 0, 32'h0, 0, "ld_40");

        // LATENCY=0 back-to-back
        for (int i = 0; i < 4; i++)
            txn(2, 1, 32'(4 * i), 2'b10, 0, $urandom, 0, "l0_st");
        for (int i = 0; i < 4; i++) begin
            t_prev = last_acc;
            txn(2, 0, 32'(4 * i + (i % 2) * 2), (i % 2 == 1) ? 2'b01 : 2'b10, 0, 32'h0, 0, "l0_ld");
            check("l0_period", 33'(last_acc - t_prev), 33'd20);
        end
        txn(2, 0, 32'h7, 2'b00, 0, 32'h0, 0, "l0_ld_b7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
